// File: rtl/shift_reg_frame_ctrl.sv
// Frame sequencer for an external serial-in shift register.
// Takes a parallel word over valid/ready and sends it out on ser with en held
// high for WIDTH cycles. It then pulses latch for one cycle, waits an optional
// idle gap, and returns to idle. Completed frames are counted in frame_cnt.
module shift_reg_frame_ctrl #(
  parameter int WIDTH      = 8,
  parameter int MSB_FIRST  = 1,
  parameter int GAP_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst,        // async, active low
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  input  logic             abort,
  output logic             ser,
  output logic             en,
  output logic             latch,
  output logic             busy,
  output logic [7:0]       frame_cnt
);

  localparam int CW = $clog2(WIDTH);
  // keep the gap counter at least one bit wide so GAP_CYCLES=0 still elaborates
  localparam int GW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
  localparam logic [GW-1:0] GAP_LAST = (GAP_CYCLES > 0) ? GW'(GAP_CYCLES - 1) : '0;

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_LATCH, S_GAP} state_t;

  state_t           state, state_nx;
  logic [WIDTH-1:0] sr, sr_nx;        // bits not yet presented on ser
  logic [CW-1:0]    cnt, cnt_nx;      // index of the en cycle currently on the wire
  logic [GW-1:0]    gcnt, gcnt_nx;
  logic             ser_nx, en_nx, latch_nx, busy_nx;
  logic [7:0]       frame_cnt_nx;

  // Bit that goes out next, in the configured order.
  function automatic logic first_bit(input logic [WIDTH-1:0] w);
    return (MSB_FIRST != 0) ? w[WIDTH-1] : w[0];
  endfunction

  // Drop the bit just sent so the next one sits in the same position.
  function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] w);
    return (MSB_FIRST != 0) ? {w[WIDTH-2:0], 1'b0} : {1'b0, w[WIDTH-1:1]};
  endfunction

  // Ready is the only combinational output. An abort in idle blocks acceptance.
  assign din_ready = (state == S_IDLE) && !abort;

  // Next-state logic. The outputs are computed for the upcoming cycle, so the
  // register stage presents them aligned with the state they belong to.
  always_comb begin
    state_nx     = state;
    sr_nx        = sr;
    cnt_nx       = cnt;
    gcnt_nx      = gcnt;
    ser_nx       = 1'b0;
    en_nx        = 1'b0;
    latch_nx     = 1'b0;
    frame_cnt_nx = frame_cnt;
    case (state)
      S_IDLE: begin
        if (din_valid && din_ready) begin
          state_nx = S_SHIFT;
          sr_nx    = advance(din);
          cnt_nx   = '0;
          en_nx    = 1'b1;
          ser_nx   = first_bit(din);
        end
      end
      S_SHIFT: begin
        if (abort) begin
          // leave a partial frame in the shift register; no latch, no gap
          state_nx = S_IDLE;
        end else if (cnt == CNT_LAST) begin
          state_nx     = S_LATCH;
          latch_nx     = 1'b1;
          frame_cnt_nx = frame_cnt + 8'd1;
        end else begin
          cnt_nx = cnt + 1'b1;
          en_nx  = 1'b1;
          ser_nx = first_bit(sr);
          sr_nx  = advance(sr);
        end
      end
      S_LATCH: begin
        if (GAP_CYCLES > 0) begin
          state_nx = S_GAP;
          gcnt_nx  = '0;
        end else begin
          state_nx = S_IDLE;
        end
      end
      S_GAP: begin
        if (gcnt == GAP_LAST) state_nx = S_IDLE;
        else                  gcnt_nx  = gcnt + 1'b1;
      end
      default: state_nx = S_IDLE;
    endcase
    busy_nx = (state_nx != S_IDLE);
  end

  // State, datapath and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      sr        <= '0;
      cnt       <= '0;
      gcnt      <= '0;
      ser       <= 1'b0;
      en        <= 1'b0;
      latch     <= 1'b0;
      busy      <= 1'b0;
      frame_cnt <= 8'd0;
    end else begin
      state     <= state_nx;
      sr        <= sr_nx;
      cnt       <= cnt_nx;
      gcnt      <= gcnt_nx;
      ser       <= ser_nx;
      en        <= en_nx;
      latch     <= latch_nx;
      busy      <= busy_nx;
      frame_cnt <= frame_cnt_nx;
    end
  end

endmodule
